csr_int_ctrl: RTL and testbench

Machine-mode CSR file and interrupt/trap controller.
- Consumes the CSR write stream (csr_we/csr_waddr/csr_wdata) from the MEM/WB pipeline register.
- Serves combinational CSR reads to the decode stage.
- Sequences trap entry (ecall, external/timer interrupt) and mret.
- Produces the flush_int pulse and redirect address consumed by the pipeline registers and PC unit.

---
 rtl/csr_int_ctrl.sv | 165 ++++++++++++++++
 tb/tb_csr_int_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/csr_int_ctrl.sv
// Machine-mode CSR file with trap/mret sequencing. Produces a one-cycle
// flush strobe plus redirect target whenever a trap is entered or mret retires.
module csr_int_ctrl #(
  parameter int             CSR_AW    = 12,
  parameter int             DW        = 32,
  parameter logic [DW-1:0]  MTVEC_RST = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              csr_we_i,
  input  logic [CSR_AW-1:0] csr_waddr_i,
  input  logic [DW-1:0]     csr_wdata_i,
  input  logic [CSR_AW-1:0] csr_raddr_i,
  output logic [DW-1:0]     csr_rdata_o,
  input  logic              ecall_i,
  input  logic              mret_i,
  input  logic [DW-1:0]     inst_addr_i,
  input  logic              ext_irq_i,
  input  logic              timer_irq_i,
  output logic              flush_int_o,
  output logic [DW-1:0]     int_addr_o
);

  localparam logic [CSR_AW-1:0] A_MSTATUS  = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MIE      = CSR_AW'(12'h304);
  localparam logic [CSR_AW-1:0] A_MTVEC    = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] A_MSCRATCH = CSR_AW'(12'h340);
  localparam logic [CSR_AW-1:0] A_MEPC     = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] A_MCAUSE   = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] A_MIP      = CSR_AW'(12'h344);

  localparam logic [DW-1:0] MSTATUS_MASK = DW'(32'h0000_0088);
  localparam logic [DW-1:0] MIE_MASK     = DW'(32'h0000_0880);
  localparam logic [DW-1:0] CAUSE_ECALL  = DW'(32'd11);
  localparam logic [DW-1:0] CAUSE_EXT    = DW'(32'h8000_000B);
  localparam logic [DW-1:0] CAUSE_TMR    = DW'(32'h8000_0007);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e          state_q, state_d;
  logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic            mtie_q, mtie_d, meie_q, meie_d;
  logic [DW-1:0]   mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [DW-1:0]   mepc_q, mepc_d, mcause_q, mcause_d;
  logic [DW-1:0]   int_addr_q, int_addr_d;
  logic [DW-1:0]   mstatus_rd, mie_rd, mip_rd;
  logic            irq_ext, irq_tmr;

  always_comb begin
    mstatus_rd     = '0;
    mstatus_rd[3]  = st_mie_q;
    mstatus_rd[7]  = st_mpie_q;
    mie_rd         = '0;
    mie_rd[7]      = mtie_q;
    mie_rd[11]     = meie_q;
    mip_rd         = '0;
    mip_rd[7]      = timer_irq_i;
    mip_rd[11]     = ext_irq_i;
  end

  // Read port bypasses the in-flight WB write so decode never sees stale data;
  // mip is read-only so it never takes the bypass.
  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      A_MSTATUS:  csr_rdata_o = mstatus_rd;
      A_MIE:      csr_rdata_o = mie_rd;
      A_MTVEC:    csr_rdata_o = mtvec_q;
      A_MSCRATCH: csr_rdata_o = mscratch_q;
      A_MEPC:     csr_rdata_o = mepc_q;
      A_MCAUSE:   csr_rdata_o = mcause_q;
      A_MIP:      csr_rdata_o = mip_rd;
      default:    csr_rdata_o = '0;
    endcase
    if (csr_we_i && (csr_waddr_i == csr_raddr_i)) begin
      case (csr_waddr_i)
        A_MSTATUS: csr_rdata_o = csr_wdata_i & MSTATUS_MASK;
        A_MIE:     csr_rdata_o = csr_wdata_i & MIE_MASK;
        A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE: csr_rdata_o = csr_wdata_i;
        default: ;
      endcase
    end
  end

  assign irq_ext = st_mie_q & ext_irq_i   & meie_q;
  assign irq_tmr = st_mie_q & timer_irq_i & mtie_q;

  always_comb begin
    state_d    = IDLE;
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mtie_d     = mtie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    int_addr_d = int_addr_q;

    if (csr_we_i) begin
      case (csr_waddr_i)
        A_MSTATUS: begin
          st_mie_d  = csr_wdata_i[3];
          st_mpie_d = csr_wdata_i[7];
        end
        A_MIE: begin
          mtie_d = csr_wdata_i[7];
          meie_d = csr_wdata_i[11];
        end
        A_MTVEC:    mtvec_d    = csr_wdata_i;
        A_MSCRATCH: mscratch_d = csr_wdata_i;
        A_MEPC:     mepc_d     = csr_wdata_i;
        A_MCAUSE:   mcause_d   = csr_wdata_i;
        default: ;
      endcase
    end

    // Trap/mret updates come after the WB write so they win on a collision.
    if (state_q == IDLE) begin
      if (mret_i) begin
        st_mie_d   = st_mpie_q;
        st_mpie_d  = 1'b1;
        int_addr_d = mepc_q;
        state_d    = FLUSH;
      end else if (ecall_i || irq_ext || irq_tmr) begin
        mepc_d     = inst_addr_i;
        mcause_d   = ecall_i ? CAUSE_ECALL : (irq_ext ? CAUSE_EXT : CAUSE_TMR);
        st_mpie_d  = st_mie_q;
        st_mie_d   = 1'b0;
        int_addr_d = {mtvec_q[DW-1:2], 2'b00};
        state_d    = FLUSH;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      int_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mtie_q     <= mtie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      int_addr_q <= int_addr_d;
    end
  end

  assign flush_int_o = (state_q == FLUSH);
  assign int_addr_o  = int_addr_q;

endmodule

// File: tb/tb_csr_int_ctrl.sv
// Scoreboarded bench for csr_int_ctrl: expected redirect targets are queued
// as events are driven and matched when the flush strobe appears.
module tb_csr_int_ctrl;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;

  logic        clk = 1'b0, rst = 1'b1;
  logic        csr_we = 1'b0;
  logic [11:0] csr_waddr = '0, csr_raddr = '0;
  logic [31:0] csr_wdata = '0, csr_rdata;
  logic        ecall = 1'b0, mret = 1'b0, ext_irq = 1'b0, timer_irq = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        flush_int;
  logic [31:0] int_addr;

  int n_chk = 0, n_err = 0;
  logic [31:0] exp_q[$];

  csr_int_ctrl #(.CSR_AW(12), .DW(32), .MTVEC_RST(MTVEC_RST)) dut (
    .clk_i(clk), .rst_i(rst),
    .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
    .csr_raddr_i(csr_raddr), .csr_rdata_o(csr_rdata),
    .ecall_i(ecall), .mret_i(mret), .inst_addr_i(inst_addr),
    .ext_irq_i(ext_irq), .timer_irq_i(timer_irq),
    .flush_int_o(flush_int), .int_addr_o(int_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    csr_raddr = a; #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  // Every flush must correspond to a queued expectation.
  always @(negedge clk) begin
    if (flush_int) begin
      if (exp_q.size() == 0) chk("spurious_flush", 32'd1, 32'd0);
      else chk("redirect", int_addr, exp_q.pop_front());
    end
  end

  initial begin
    #12;
    chk("rst_flush", {31'd0, flush_int}, 32'd0);
    chk("rst_int_addr", int_addr, 32'd0);
    tick(); rst = 1'b0; tick();

    rd(12'h300, 32'h0, "rst_mstatus");
    rd(12'h304, 32'h0, "rst_mie");
    rd(12'h305, MTVEC_RST, "rst_mtvec");
    rd(12'h340, 32'h0, "rst_mscratch");
    rd(12'h341, 32'h0, "rst_mepc");
    rd(12'h342, 32'h0, "rst_mcause");
    rd(12'h344, 32'h0, "rst_mip");
    timer_irq = 1'b1; rd(12'h344, 32'h80, "mip_tmr");
    ext_irq = 1'b1;   rd(12'h344, 32'h880, "mip_both");
    timer_irq = 1'b0; ext_irq = 1'b0;
    rd(12'h123, 32'h0, "unimpl_rd");
    tick();

    wr(12'h344, 32'hFFFF_FFFF);
    rd(12'h344, 32'h0, "mip_ro");
    wr(12'h123, 32'hFFFF_FFFF);
    rd(12'h123, 32'h0, "unimpl_wr");

    // Same-cycle bypass, including masking of sparse registers
    csr_we = 1'b1; csr_waddr = 12'h305; csr_wdata = 32'h0000_0103;
    rd(12'h305, 32'h0000_0103, "byp_mtvec");
    tick(); csr_we = 1'b0;
    rd(12'h305, 32'h0000_0103, "mtvec_full");
    csr_we = 1'b1; csr_waddr = 12'h300; csr_wdata = 32'hFFFF_FFF7;
    rd(12'h300, 32'h80, "byp_mstatus_mask");
    tick(); csr_we = 1'b0;
    csr_we = 1'b1; csr_waddr = 12'h304; csr_wdata = 32'hFFFF_FFFF;
    rd(12'h304, 32'h880, "byp_mie_mask");
    tick(); csr_we = 1'b0;
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h80);
    rd(12'h300, 32'h8, "mstatus_en");
    rd(12'h304, 32'h80, "mie_en");

    // Timer interrupt
    timer_irq = 1'b1; inst_addr = 32'h40; exp_q.push_back(32'h100);
    tick(); timer_irq = 1'b0;
    tick();
    rd(12'h341, 32'h40, "tmr_mepc");
    rd(12'h342, 32'h8000_0007, "tmr_mcause");
    rd(12'h300, 32'h80, "tmr_mstatus");

    // mret back to the interrupted PC
    mret = 1'b1; exp_q.push_back(32'h40);
    tick(); mret = 1'b0;
    tick();
    rd(12'h300, 32'h88, "mret_mstatus");

    // ecall beats a simultaneous external irq; ecall during FLUSH is dropped
    wr(12'h304, 32'h800);
    ext_irq = 1'b1; ecall = 1'b1; inst_addr = 32'h80; exp_q.push_back(32'h100);
    tick(); inst_addr = 32'h44;
    tick(); ecall = 1'b0; ext_irq = 1'b0;
    tick();
    rd(12'h342, 32'd11, "ecall_prio_mcause");
    rd(12'h341, 32'h80, "ecall_prio_mepc");
    rd(12'h300, 32'h80, "ecall_mstatus");

    // Hardware mepc update wins over WB write on the same edge
    csr_we = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'hDEAD;
    ecall = 1'b1; inst_addr = 32'h10; exp_q.push_back(32'h100);
    tick(); csr_we = 1'b0; ecall = 1'b0;
    tick();
    rd(12'h341, 32'h10, "wb_vs_trap_mepc");

    wr(12'h340, 32'hCAFE);
    rd(12'h340, 32'hCAFE, "mscratch");

    // External interrupt
    wr(12'h300, 32'h8);
    ext_irq = 1'b1; inst_addr = 32'h60; exp_q.push_back(32'h100);
    tick(); ext_irq = 1'b0;
    tick();
    rd(12'h342, 32'h8000_000B, "ext_mcause");
    rd(12'h341, 32'h60, "ext_mepc");
    tick(); tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a flush
    ecall = 1'b1; inst_addr = 32'h24;
    tick(); ecall = 1'b0;
    chk("flush_before_rst", {31'd0, flush_int}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_flush", {31'd0, flush_int}, 32'd0);
    chk("rst_mid_int_addr", int_addr, 32'd0);
    rd(12'h300, 32'h0, "rst2_mstatus");
    rd(12'h304, 32'h0, "rst2_mie");
    rd(12'h305, MTVEC_RST, "rst2_mtvec");
    rd(12'h340, 32'h0, "rst2_mscratch");
    rd(12'h341, 32'h0, "rst2_mepc");
    rd(12'h342, 32'h0, "rst2_mcause");
    tick(); rst = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
